// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_DATA_WIDTH    : operand/result width
//   DIV_CNT_WIDTH     : iteration counter width, clog2(width)+1
//   div_state_e       : FSM state encoding (IDLE/CALC/FIX/DONE)
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor (all ones)
package iter_divider_pkg;

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_CNT_WIDTH  = $clog2(DIV_DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam logic [DIV_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/iter_divider_div_trial_sub.sv
// Trial subtractor for restoring division.
// Ports:
//   minuend_i    : shifted partial remainder (WIDTH bits)
//   subtrahend_i : zero-extended divisor magnitude (WIDTH bits)
//   diff_o       : minuend_i - subtrahend_i
//   nonneg_o     : 1 when the difference is non-negative
module div_trial_sub
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DIV_DATA_WIDTH + 1
) (
    input  logic [WIDTH-1:0] minuend_i,
    input  logic [WIDTH-1:0] subtrahend_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             nonneg_o
);

    // The partial remainder is always below the divisor, so the shifted
    // value is below twice the divisor and the true difference lies in
    // (-2^(WIDTH-1), 2^(WIDTH-1)); the top bit is therefore a valid sign.
    assign diff_o   = minuend_i - subtrahend_i;
    assign nonneg_o = ~diff_o[WIDTH-1];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock), signed or
// unsigned, with a zero-divisor fast path.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : operand handshake (A, B, is_signed)
//   out_valid/ready : result handshake (Quotient, Remainder, DivZero)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE.
// Producers hold valid (and data) until the transfer; outputs are stable
// while out_valid is high and out_ready low. Quotient/Remainder/DivZero keep
// their last value after the result is consumed.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Quotient,
    output logic [DATA_WIDTH-1:0] Remainder,
    output logic                  DivZero
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e state_q, state_d;

    logic [DATA_WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit
    logic [DATA_WIDTH-1:0] quo_q, quo_d;       // dividend / quotient shift register
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic                  signed_q, signed_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] quot_out_q, quot_out_d;
    logic [DATA_WIDTH-1:0] rem_out_q, rem_out_d;
    logic                  dz_q, dz_d;

    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   trial_diff;
    logic                  trial_nonneg;

    // Magnitudes only for signed operations; the most negative value maps
    // onto itself, which is the correct unsigned magnitude.
    assign abs_a = (is_signed && A[DATA_WIDTH-1]) ? -A : A;
    assign abs_b = (is_signed && B[DATA_WIDTH-1]) ? -B : B;

    // Shift {rem, q} left by one: the dividend MSB enters the remainder.
    assign rem_shift = (rem_q << 1) | {{DATA_WIDTH{1'b0}}, quo_q[DATA_WIDTH-1]};

    div_trial_sub #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_trial_sub (
        .minuend_i    (rem_shift),
        .subtrahend_i ({1'b0, dvs_q}),
        .diff_o       (trial_diff),
        .nonneg_o     (trial_nonneg)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        signed_d   = signed_q;
        cnt_d      = cnt_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dz_d       = dz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvs_d    = abs_b;
                    sign_a_d = is_signed & A[DATA_WIDTH-1];
                    sign_b_d = is_signed & B[DATA_WIDTH-1];
                    signed_d = is_signed;
                    if (B == '0) begin
                        quot_out_d = DIV_ZERO_QUOTIENT;
                        rem_out_d  = A;
                        dz_d       = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (trial_nonneg) begin
                    rem_d = trial_diff;
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Remainder is always below the divisor, so its guard bit is 0.
                if (signed_q) begin
                    quot_out_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                    rem_out_d  = sign_a_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
                end else begin
                    quot_out_d = quo_q;
                    rem_out_d  = rem_q[DATA_WIDTH-1:0];
                end
                dz_d    = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            signed_q   <= 1'b0;
            cnt_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            signed_q   <= signed_d;
            cnt_q      <= cnt_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dz_q       <= dz_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Quotient  = quot_out_q;
    assign Remainder = rem_out_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed and random divides, zero
// divisor, signed overflow, output backpressure and reset during CALC.
module tb_iter_divider;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivZero;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected results packed as {DivZero, Quotient, Remainder}.
    logic [2*W:0] exp_q[$];

    iter_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model built on native 32-bit unsigned division of magnitudes.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W-1:0] ma, mb, mq, mr, q, r;
        logic         na, nb;
        if (b == '0) begin
            return {1'b1, {W{1'b1}}, a};
        end
        na = s & a[W-1];
        nb = s & b[W-1];
        ma = na ? (~a + 1'b1) : a;
        mb = nb ? (~b + 1'b1) : b;
        mq = ma / mb;
        mr = ma % mb;
        q  = (na ^ nb) ? (~mq + 1'b1) : mq;
        r  = na ? (~mr + 1'b1) : mr;
        return {1'b0, q, r};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int waited;
        A         = a;
        B         = b;
        is_signed = s;
        in_valid  = 1'b1;
        waited    = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        exp_q.push_back(model(a, b, s));
        tick();                           // accept edge
        in_valid = 1'b0;
    endtask

    // Wait for a result, compare against the scoreboard, then consume it.
    // exp_lat < 0 skips the latency comparison.
    task automatic receive(input int exp_lat);
        int           lat;
        logic [2*W:0] exp;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        if (exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("quotient",  64'(Quotient),  64'(exp[2*W-1:W]));
        check("remainder", 64'(Remainder), 64'(exp[W-1:0]));
        check("divzero",   {63'd0, DivZero}, {63'd0, exp[2*W]});
        check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_hs",  {63'd0, in_ready},  64'd1);
        check("quotient_hold",      64'(Quotient), 64'(exp[2*W-1:W]));
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int exp_lat);
        send(a, b, s);
        receive(exp_lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2*W:0] head;
        int           waited;

        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_quotient",  64'(Quotient),  64'd0);
        check("rst_remainder", 64'(Remainder), 64'd0);
        check("rst_divzero",   {63'd0, DivZero}, 64'd0);

        // Directed divides
        run_div(32'd100,        32'd7,          1'b0, NORMAL_LAT);
        run_div(32'hFFFFFFF9,   32'd2,          1'b1, NORMAL_LAT);
        run_div(32'd7,          32'hFFFFFFFE,   1'b1, NORMAL_LAT);
        // Zero divisor: result is visible straight after the accept edge
        run_div(32'h1234,       32'd0,          1'b0, 0);
        run_div(32'h1234,       32'd0,          1'b1, 0);
        run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, NORMAL_LAT);
        run_div(32'hFFFFFFFF,   32'd1,          1'b0, NORMAL_LAT);
        run_div(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, NORMAL_LAT);
        run_div(32'd5,          32'd9,          1'b0, NORMAL_LAT);

        // Random divides, signed and unsigned
        for (int i = 0; i < 8; i++) begin
            run_div($urandom, $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16),
                    1'(i % 2), NORMAL_LAT);
        end

        // Backpressure: hold the result with in_valid pulses arriving
        send(32'd200, 32'd9, 1'b0);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        head = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            A         = $urandom;
            B         = $urandom;
            in_valid  = 1'(i % 2);
            tick();
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_quotient",  64'(Quotient),  64'(head[2*W-1:W]));
            check("bp_remainder", 64'(Remainder), 64'(head[W-1:0]));
        end
        in_valid = 1'b0;
        receive(-1);
        repeat (3) tick();
        check("bp_no_ghost_request", {63'd0, out_valid}, 64'd0);

        // Reset during CALC abandons the operation
        send(32'd1000, 32'd3, 1'b0);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("midrst_quotient",  64'(Quotient),  64'd0);
        check("midrst_remainder", 64'(Remainder), 64'd0);
        check("midrst_divzero",   {63'd0, DivZero}, 64'd0);
        repeat (40) tick();
        check("midrst_no_result", {63'd0, out_valid}, 64'd0);
        run_div(32'd9, 32'd3, 1'b0, NORMAL_LAT);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
